// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Two-requester round-robin front end for a single shared combinational ALU.
// A granted request has its operands and opcode registered onto the ALU
// inputs, the ALU output is captured one cycle later, and the captured result
// is held on the response port until the consumer takes it. Only one
// operation is in flight at a time.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  requester N handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_sel requester N operands and opcode
//   alu_a, alu_b, alu_sel    registered operands/opcode to the shared ALU
//   alu_y, alu_flag          combinational ALU result and flag
//   resp_valid / resp_ready  response handshake
//   resp_id                  requester that owns the current response
//   resp_y, resp_flag        captured ALU result and flag
//   busy                     high whenever the FSM is not idle
//   ops_done                 completed-response count, wraps at 256

module alu_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SELW  = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SELW-1:0]  req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SELW-1:0]  req1_sel,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [1:0]       alu_flag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_y,
    output logic [1:0]       resp_flag,

    output logic             busy,
    output logic [7:0]       ops_done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SELW-1:0]  alu_sel_q, alu_sel_d;
    logic             last_grant_q, last_grant_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_y_q, resp_y_d;
    logic [1:0]       resp_flag_q, resp_flag_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       ops_done_q, ops_done_d;

    logic grant0;
    logic grant1;

    // Round-robin: on a tie the requester that was not granted last wins.
    // last_grant is a single bit, so at most one grant can be high.
    always_comb begin
        grant0 = (state_q == StIdle) && req0_valid && (!req1_valid || last_grant_q);
        grant1 = (state_q == StIdle) && req1_valid && (!req0_valid || !last_grant_q);
    end

    // Ready is forced low during reset so nothing is handed off to a
    // machine that is being cleared.
    assign req0_ready = grant0 && !rst;
    assign req1_ready = grant1 && !rst;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        last_grant_d = last_grant_q;
        resp_id_d    = resp_id_q;
        resp_y_d     = resp_y_q;
        resp_flag_d  = resp_flag_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        ops_done_d   = ops_done_q;

        case (state_q)
            StIdle: begin
                if (grant0) begin
                    alu_a_d      = req0_a;
                    alu_b_d      = req0_b;
                    alu_sel_d    = req0_sel;
                    last_grant_d = 1'b0;
                    resp_id_d    = 1'b0;
                    state_d      = StIssue;
                    busy_d       = 1'b1;
                end else if (grant1) begin
                    alu_a_d      = req1_a;
                    alu_b_d      = req1_b;
                    alu_sel_d    = req1_sel;
                    last_grant_d = 1'b1;
                    resp_id_d    = 1'b1;
                    state_d      = StIssue;
                    busy_d       = 1'b1;
                end
            end

            StIssue: begin
                // ALU inputs have been stable for a full cycle; capture result.
                resp_y_d     = alu_y;
                resp_flag_d  = alu_flag;
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end

            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    ops_done_d   = ops_done_q + 8'd1;
                    state_d      = StIdle;
                end
            end

            default: begin
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = StIdle;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            last_grant_q <= 1'b1;
            resp_id_q    <= 1'b0;
            resp_y_q     <= '0;
            resp_flag_q  <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            last_grant_q <= last_grant_d;
            resp_id_q    <= resp_id_d;
            resp_y_q     <= resp_y_d;
            resp_flag_q  <= resp_flag_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign resp_id    = resp_id_q;
    assign resp_y     = resp_y_q;
    assign resp_flag  = resp_flag_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//
// Directed bench for alu_arbiter with an XOR ALU stub (alu_y = a ^ b,
// alu_flag = 2'b01). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.

module tb_alu_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SELW  = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [SELW-1:0]  req0_sel;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [SELW-1:0]  req1_sel;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [SELW-1:0]  alu_sel;
    logic [1:0]       alu_flag;
    logic             resp_valid, resp_ready, resp_id;
    logic [WIDTH-1:0] resp_y;
    logic [1:0]       resp_flag;
    logic             busy;
    logic [7:0]       ops_done;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_y      (alu_y),
        .alu_flag   (alu_flag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_flag  (resp_flag),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    assign alu_y    = alu_a ^ alu_b;
    assign alu_flag = 2'b01;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
        resp_ready = 1'b0;
        #2;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;

        // Reset state, with both requesters knocking
        @(negedge clk);
        check_eq("rst_r0", req0_ready, 0);
        check_eq("rst_r1", req1_ready, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_b", alu_b, 0);
        check_eq("rst_alu_sel", alu_sel, 0);
        check_eq("rst_rv", resp_valid, 0);
        check_eq("rst_y", resp_y, 0);
        check_eq("rst_flag", resp_flag, 0);
        check_eq("rst_id", resp_id, 0);
        check_eq("rst_ops", ops_done, 0);
        check_eq("rst_busy", busy, 0);
        next_cycle();

        // Single op from req0
        rst        = 1'b0;
        req1_valid = 1'b0;
        req0_a = 8'h0C; req0_b = 8'h09; req0_sel = 4'h1;
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("s_r0", req0_ready, 1);
        check_eq("s_r1", req1_ready, 0);
        check_eq("s_busy0", busy, 0);
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("s_busy1", busy, 1);
        check_eq("s_rv1", resp_valid, 0);
        check_eq("s_alu_a", alu_a, 8'h0C);
        check_eq("s_alu_b", alu_b, 8'h09);
        check_eq("s_alu_sel", alu_sel, 4'h1);
        next_cycle();
        @(negedge clk);
        check_eq("s_rv2", resp_valid, 1);
        check_eq("s_y", resp_y, 8'h05);
        check_eq("s_flag", resp_flag, 2'b01);
        check_eq("s_id", resp_id, 0);
        next_cycle();
        @(negedge clk);
        check_eq("s_rv3", resp_valid, 0);
        check_eq("s_busy3", busy, 0);
        check_eq("s_ops", ops_done, 1);
        next_cycle();

        // Backpressure on a req0 result while req1 waits
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h0F; req0_sel = 4'h7;
        resp_ready = 1'b0;
        @(negedge clk);
        check_eq("bp_r0", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'hA0; req1_b = 8'h05; req1_sel = 4'h2;
        @(negedge clk);
        check_eq("bp_issue_r1", req1_ready, 0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_rv", resp_valid, 1);
            check_eq("bp_y", resp_y, 8'h3C);
            check_eq("bp_r0", req0_ready, 0);
            check_eq("bp_r1", req1_ready, 0);
            check_eq("bp_busy", busy, 1);
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_rel_rv", resp_valid, 1);
        check_eq("bp_rel_y", resp_y, 8'h3C);
        next_cycle();
        @(negedge clk);
        check_eq("bp_idle_busy", busy, 0);
        check_eq("bp_idle_rv", resp_valid, 0);
        check_eq("bp_wait_r1", req1_ready, 1);
        check_eq("bp_ops", ops_done, 2);
        next_cycle();
        req1_valid = 1'b0;
        @(negedge clk);
        check_eq("w_alu_a", alu_a, 8'hA0);
        next_cycle();
        @(negedge clk);
        check_eq("w_rv", resp_valid, 1);
        check_eq("w_y", resp_y, 8'hA5);
        check_eq("w_id", resp_id, 1);
        next_cycle();
        @(negedge clk);
        check_eq("w_ops", ops_done, 3);
        next_cycle();

        // Tie: both held, strictly alternating, 3 cycles apart
        req0_valid = 1'b1; req0_a = 8'hCC; req0_b = 8'hC9; req0_sel = 4'h3;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'hFF; req1_sel = 4'h4;
        for (int cyc = 0; cyc < 12; cyc++) begin
            int slot;
            int turn;
            slot = cyc % 3;
            turn = (cyc / 3) % 2;
            @(negedge clk);
            check_eq("tie_r0", req0_ready, (slot == 0 && turn == 0) ? 1 : 0);
            check_eq("tie_r1", req1_ready, (slot == 0 && turn == 1) ? 1 : 0);
            check_eq("tie_rv", resp_valid, (slot == 2) ? 1 : 0);
            if (slot == 2) begin
                check_eq("tie_y", resp_y, (turn == 1) ? 8'hFF : 8'h05);
                check_eq("tie_id", resp_id, turn);
            end
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check_eq("tie_ops", ops_done, 7);
        next_cycle();

        // Reset during ISSUE discards the op; req0 wins the next tie
        req0_valid = 1'b1;
        @(negedge clk);
        check_eq("ri_r0", req0_ready, 1);
        next_cycle();
        rst        = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check_eq("ri_busy", busy, 0);
        check_eq("ri_rv", resp_valid, 0);
        check_eq("ri_ops", ops_done, 0);
        check_eq("ri_alu_a", alu_a, 0);
        check_eq("ri_r0_rst", req0_ready, 0);
        check_eq("ri_r1_rst", req1_ready, 0);
        next_cycle();
        next_cycle();
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("ri_no_rv", resp_valid, 0);
            next_cycle();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check_eq("ri_tie_r0", req0_ready, 1);
        check_eq("ri_tie_r1", req1_ready, 0);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check_eq("ri_y", resp_y, 8'h05);
        check_eq("ri_id", resp_id, 0);
        next_cycle();
        @(negedge clk);
        check_eq("ri_ops1", ops_done, 1);
        next_cycle();

        // Counter wrap over 256 back-to-back ops
        rst = 1'b1;
        next_cycle();
        rst        = 1'b0;
        req0_valid = 1'b1;
        repeat (765) @(posedge clk);
        @(negedge clk);
        check_eq("wrap_255", ops_done, 255);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("wrap_0", ops_done, 0);
        req0_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
